// File: rtl/mdu_pkg.sv
// Shared MD-unit definitions: op encodings used by the controller, hazard unit and mdu.
package mdu_defs;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: result is computed at the start edge, held
// pending for a fixed latency, then committed to HI/LO as the counter reaches zero.
module mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDU_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] result
);

  logic [3:0]         cnt;
  logic [31:0]        hi_q, lo_q;
  md_result_t         pend, calc;
  logic               pend_wr;
  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic [31:0]        sdiv_b, udiv_b;

  assign busy = (cnt != 4'd0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Divisor is forced to 1 for divide-by-zero (never committed) and for the
  // signed overflow case, where A/1 already yields the required 0x80000000 rem 0.
  always_comb begin
    smul   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    umul   = {32'd0, A} * {32'd0, B};
    sdiv_b = ((B == 32'd0) || (A == 32'h8000_0000 && B == 32'hFFFF_FFFF)) ? 32'd1 : B;
    udiv_b = (B == 32'd0) ? 32'd1 : B;
    calc   = '0;
    case (MDU_op)
      MDU_MULT:  calc = '{hi: smul[63:32], lo: smul[31:0]};
      MDU_MULTU: calc = '{hi: umul[63:32], lo: umul[31:0]};
      MDU_DIV: begin
        calc.lo = $signed(A) / $signed(sdiv_b);
        calc.hi = $signed(A) % $signed(sdiv_b);
      end
      MDU_DIVU: begin
        calc.lo = A / udiv_b;
        calc.hi = A % udiv_b;
      end
      default: calc = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend    <= '0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      // Any start while busy is dropped; only the countdown advances.
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && pend_wr) begin
        hi_q <= pend.hi;
        lo_q <= pend.lo;
      end
    end else if (start) begin
      case (MDU_op)
        MDU_MULT, MDU_MULTU: begin
          cnt     <= 4'(MULT_CYCLES);
          pend    <= calc;
          pend_wr <= 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          cnt     <= 4'(DIV_CYCLES);
          pend    <= calc;
          pend_wr <= (B != 32'd0);
        end
        MDU_MTHI: hi_q <= A;
        MDU_MTLO: lo_q <= A;
        default: ;
      endcase
    end
  end

  always_comb begin
    result = 32'd0;
    if (MDU_op == MDU_MFHI)      result = hi_q;
    else if (MDU_op == MDU_MFLO) result = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues expected busy length and HI/LO,
// a monitor pops and compares each time busy falls.
module tb_mdu;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDU_op;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO, result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDU_op(MDU_op), .start(start),
    .busy(busy), .HI(HI), .LO(LO), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDU_op = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDU_op = MDU_NONE;
  endtask

  task automatic expect_op(input string name, input int cyc, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name; e.cyc = cyc; e.hi = hi; e.lo = lo;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  // MFHI/MFLO/NONE read-port check within the low clock phase
  task automatic check_rd(input string name, input logic [31:0] hi, input logic [31:0] lo);
    #1 MDU_op = MDU_MFHI;
    #1 chk({name, "_mfhi"}, result, hi);
    MDU_op = MDU_MFLO;
    #1 chk({name, "_mflo"}, result, lo);
    MDU_op = MDU_NONE;
    #1 chk({name, "_none"}, result, 32'd0);
  endtask

  // Monitor: count busy cycles at each negedge; on the falling edge compare.
  initial begin
    int  bc = 0;
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) bc++;
      else if (prev) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_busy_cycles"}, 32'(bc), 32'(e.cyc));
          chk({e.name, "_hi"}, HI, e.hi);
          chk({e.name, "_lo"}, LO, e.lo);
        end
        bc = 0;
      end
      prev = busy;
    end
  end

  initial begin
    reset = 1'b1; A = '0; B = '0; MDU_op = MDU_NONE; start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_result", result, 32'd0);

    expect_op("mult_neg", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult_neg");
    check_rd("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    expect_op("multu_max", 5, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("multu_max");

    expect_op("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg");

    expect_op("divu", 10, 32'd1, 32'd3);
    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle("divu");
    check_rd("divu", 32'd1, 32'd3);

    expect_op("div_ovf", 10, 32'd0, 32'h8000_0000);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    issue(MDU_MTHI, 32'h1234, 32'd0);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    issue(MDU_MTLO, 32'h5678, 32'd0);
    check_rd("mt", 32'h1234, 32'h5678);

    expect_op("divu_zero", 10, 32'h1234, 32'h5678);
    issue(MDU_DIVU, 32'd9, 32'd0);
    wait_idle("divu_zero");

    // MTLO arriving while busy must be dropped
    expect_op("mult_ign_mt", 5, 32'd0, 32'd42);
    issue(MDU_MULT, 32'd6, 32'd7);
    MDU_op = MDU_MTLO; A = 32'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDU_op = MDU_NONE;
    wait_idle("mult_ign_mt");
    check_rd("mult_ign_mt", 32'd0, 32'd42);

    // Operands change during busy; result must use captured values
    expect_op("mult_capture", 5, 32'd1, 32'd0);
    issue(MDU_MULT, 32'h0001_0000, 32'h0001_0000);
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    wait_idle("mult_capture");

    // Reset in busy cycle 4 aborts the divide
    expect_op("div_reset", 4, 32'd0, 32'd0);
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("div_reset_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    chk("div_reset_hi_late", HI, 32'd0);
    chk("div_reset_lo_late", LO, 32'd0);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
